multicycle_controller: RTL and testbench

Multi-cycle sequencer for the RV32I core. Steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. Owns the PC and instruction register, and runs the req/ready handshakes to instruction and data memory. Drives the write strobes for the register file and PC around control_unit and alu. Decode results (load/store/branch/rd) come back in from control_unit, which decodes the held instruction.

---
 rtl/multicycle_controller.sv | 149 ++++++++++++++
 tb/tb_multicycle_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : RV32I multi-cycle sequencer (FETCH/DECODE/EXECUTE/MEM/WB/HALT);
//            owns PC and IR. Optional macro RETIRE_COUNTER_EN adds instret.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            has_rd,
    input  logic [4:0]      rd,
    input  logic            illegal,
    input  logic            take_branch,
    input  logic [XLEN-1:0] target,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            rf_we,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            halted,
    output logic [2:0]      state_o
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            w_imem_req;
    logic            w_dmem_req;
    logic            w_dmem_we;
    logic            w_rf_we;
    logic            w_retire;
    logic            w_misaligned;

    assign w_misaligned = take_branch && (target[1:0] != 2'b00);

    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_rf_we    = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                w_next = illegal ? ST_HALT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_next = (is_load || is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = is_store;
                if (dmem_ready) w_next = ST_WB;
            end
            ST_WB: begin
                // A misaligned redirect stops the core without committing anything.
                if (w_misaligned) begin
                    w_next = ST_HALT;
                end else begin
                    w_rf_we  = has_rd && (rd != 5'd0);
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_instr <= c_NOP;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_FETCH) && imem_ready) begin
                r_instr <= imem_rdata;
            end
            if ((r_state == ST_WB) && !w_misaligned) begin
                r_pc <= take_branch ? target : (r_pc + XLEN'(4));
            end
        end
    end

`ifdef RETIRE_COUNTER_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instret <= 64'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

    // Strobes are forced low combinationally while reset is held.
    assign imem_req  = rst_n & w_imem_req;
    assign dmem_req  = rst_n & w_dmem_req;
    assign dmem_we   = rst_n & w_dmem_we;
    assign rf_we     = rst_n & w_rf_we;
    assign retire    = rst_n & w_retire;
    assign halted    = rst_n & (r_state == ST_HALT);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// Randomized scoreboard bench for multicycle_controller: the driver pushes the
// expected outcome of each fetched instruction, a monitor pops and compares.
module tb_multicycle_controller;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        is_load, is_store, has_rd, illegal, take_branch;
    logic [4:0]  rd;
    logic [31:0] target;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        rf_we, retire, halted;
    logic [31:0] pc;
    logic [2:0]  state_o;
`ifdef RETIRE_COUNTER_EN
    logic [63:0] instret;
`endif

    multicycle_controller #(.XLEN(32), .RESET_PC(c_RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr(instr),
        .is_load(is_load), .is_store(is_store), .has_rd(has_rd), .rd(rd),
        .illegal(illegal), .take_branch(take_branch), .target(target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .pc(pc), .retire(retire), .halted(halted), .state_o(state_o)
`ifdef RETIRE_COUNTER_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          halt;
        bit          mem;
        bit          we;
        bit          rf_we;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] next_pc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_ret    = 0;
    logic [31:0] m_pc;
    logic [31:0] exp_fetch_pc;
    bit          chk_fetch = 0;
    bit          seen_halt = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1) begin
            if (retire) begin
                if (sb.size() == 0) begin
                    chk("retire_unexpected", {63'd0, retire}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("retire_not_halt", {63'd0, mon_e.halt}, 64'd0);
                    chk("retire_pc", pc, mon_e.pc);
                    chk("retire_instr", instr, mon_e.instr);
                    chk("retire_rf_we", {63'd0, rf_we}, {63'd0, mon_e.rf_we});
                    exp_fetch_pc = mon_e.next_pc;
                    chk_fetch    = 1;
                    n_ret++;
                end
            end else if (rf_we) begin
                chk("rf_we_without_retire", {63'd0, rf_we}, 64'd0);
            end
            if (imem_req && chk_fetch) begin
                chk("fetch_addr", imem_addr, exp_fetch_pc);
                chk_fetch = 0;
            end
            if (dmem_req) begin
                if (sb.size() == 0 || !sb[0].mem) begin
                    chk("dmem_req_unexpected", {63'd0, dmem_req}, 64'd0);
                end else begin
                    chk("dmem_we", {63'd0, dmem_we}, {63'd0, sb[0].we});
                end
            end
            if (halted && !seen_halt) begin
                seen_halt = 1;
                if (sb.size() == 0) begin
                    chk("halt_unexpected", {63'd0, halted}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("halt_expected", {63'd0, mon_e.halt}, 64'd1);
                    chk("halt_pc", pc, mon_e.pc);
                end
            end
            if (halted) chk("halt_strobes", {60'd0, imem_req, dmem_req, rf_we, retire}, 64'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; imem_ready = 0; dmem_ready = 0;
        sb.delete();
        chk_fetch = 0; seen_halt = 0;
        #1;
        chk("rst_strobes", {59'd0, imem_req, dmem_req, rf_we, retire, halted}, 64'd0);
        @(negedge clk);
        chk("rst_state", {61'd0, state_o}, 64'd0);
        chk("rst_pc", pc, c_RESET_PC);
        chk("rst_instr", instr, c_NOP);
`ifdef RETIRE_COUNTER_EN
        chk("rst_instret", instret, 64'd0);
`endif
        rst_n = 1;
        m_pc = c_RESET_PC; n_ret = 0;
        exp_fetch_pc = c_RESET_PC; chk_fetch = 1;
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 branch/jump, 4 illegal
    task automatic do_instr(input int kind, input logic [31:0] tgt, input logic [4:0] rdv,
                            input bit hrd, input int iw, input int dw, input bit abort);
        exp_t        e;
        logic [31:0] w;
        int          n;
        n = 0;
        while (!imem_req && n < 64) begin @(negedge clk); n++; end
        if (!imem_req) begin chk("fetch_timeout", {63'd0, imem_req}, 64'd1); return; end
        for (int i = 0; i < iw; i++) begin
            // Junk decode inputs while fetching must be ignored.
            illegal = 1'($urandom_range(0, 1)); take_branch = 1'($urandom_range(0, 1));
            is_load = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("fetch_hold", {63'd0, imem_req}, 64'd1);
        end
        w = $urandom;
        imem_rdata = w; imem_ready = 1;
        is_load = (kind == 1); is_store = (kind == 2); illegal = (kind == 4);
        take_branch = (kind == 3); target = tgt; rd = rdv; has_rd = hrd;
        e.pc = m_pc; e.instr = w; e.mem = (kind == 1 || kind == 2); e.we = (kind == 2);
        e.halt = (kind == 4) || (kind == 3 && tgt[1:0] != 2'b00);
        e.rf_we = hrd && (rdv != 5'd0);
        e.next_pc = (kind == 3) ? tgt : m_pc + 32'd4;
        if (!e.halt) m_pc = e.next_pc;
        sb.push_back(e);
        @(negedge clk);
        imem_ready = 0; imem_rdata = $urandom;
        chk("instr_latched", instr, w);
        if (e.mem && !e.halt) begin
            n = 0;
            while (!dmem_req && n < 16) begin @(negedge clk); n++; end
            if (!dmem_req) begin chk("dmem_timeout", {63'd0, dmem_req}, 64'd1); return; end
            if (abort) begin
                repeat (2) @(negedge clk);
                do_reset();
                return;
            end
            for (int i = 0; i < dw; i++) begin
                @(negedge clk);
                chk("dmem_hold", {63'd0, dmem_req}, 64'd1);
            end
            dmem_ready = 1;
            @(negedge clk);
            dmem_ready = 0;
            chk("dmem_release", {63'd0, dmem_req}, 64'd0);
        end
    endtask

    task automatic expect_halt();
        int n;
        n = 0;
        while (!halted && n < 32) begin @(negedge clk); n++; end
        chk("halt_reached", {63'd0, halted}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            imem_ready = 1'($urandom_range(0, 1)); dmem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            @(negedge clk);
            chk("halt_sticky", {60'd0, halted, state_o}, {60'd0, 1'b1, 3'd5});
            chk("halt_pc_hold", pc, m_pc);
        end
        imem_ready = 0; dmem_ready = 0;
`ifdef RETIRE_COUNTER_EN
        chk("instret_count", instret, 64'(n_ret));
`endif
    endtask

    task automatic rand_instr();
        int          k;
        logic [31:0] t;
        k = $urandom_range(0, 3);
        t = $urandom;
        t[1:0] = 2'b00;
        do_instr(k, t, 5'($urandom_range(0, 31)), (k != 2) && ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0; imem_ready = 0; imem_rdata = 0; dmem_ready = 0;
        is_load = 0; is_store = 0; has_rd = 0; rd = 0; illegal = 0;
        take_branch = 0; target = 0;
        do_reset();
        do_instr(0, 32'h0, 5'd1, 1'b1, 0, 0, 1'b0);            // ADDI x1
        do_instr(1, 32'h0, 5'd5, 1'b1, 0, 3, 1'b0);            // load, slow dmem
        do_instr(2, 32'h0, 5'd0, 1'b0, 1, 0, 1'b0);            // store
        do_instr(3, 32'h0000_0100, 5'd0, 1'b0, 0, 0, 1'b0);    // branch to 0x100
        do_instr(3, 32'hFFFF_FFFC, 5'd1, 1'b1, 2, 0, 1'b0);    // jump to top
        do_instr(0, 32'h0, 5'd0, 1'b1, 0, 0, 1'b0);            // wraps pc to 0, rd=0
        for (int i = 0; i < 40; i++) rand_instr();
        @(negedge clk);
`ifdef RETIRE_COUNTER_EN
        chk("instret_count", instret, 64'(n_ret));
`endif
        do_instr(1, 32'h0, 5'd7, 1'b1, 0, 0, 1'b1);            // reset during MEM wait
        for (int i = 0; i < 5; i++) rand_instr();
        do_instr(3, 32'h0000_0102, 5'd1, 1'b1, 0, 0, 1'b0);    // misaligned redirect
        expect_halt();
        do_reset();
        for (int i = 0; i < 5; i++) rand_instr();
        do_instr(4, 32'h0, 5'd3, 1'b1, 1, 0, 1'b0);            // illegal opcode
        expect_halt();
        do_reset();
        do_instr(0, 32'h0, 5'd2, 1'b1, 0, 0, 1'b0);
        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
